// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences the core reset, counts run cycles, and ends the run
// on a tohost pass/fail write, a cycle-budget timeout or a stuck PC.
// Handshake note: there is no valid/ready traffic here; the tohost snoop is a
// single-cycle qualifier (dmem_we && dmem_addr == TOHOST_ADDR), and its effect
// appears on the outputs one cycle later.
module cpu_run_ctrl #(
  parameter int          RESET_CYCLES = 4,
  parameter int          MAX_CYCLES   = 100000,
  parameter int          CNT_W        = 32,
  parameter int          HANG_CYCLES  = 64,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter bit          HOLD_ON_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             dmem_we,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  // The state encoding equals the status code, so status doubles as the
  // FSM debug view.
  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]      HANG_LAST = 32'(HANG_CYCLES - 1);
  localparam bit               HANG_EN   = (HANG_CYCLES != 0);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  hold_cnt;
  logic [31:0] hang_cnt;
  logic [31:0] prev_pc;
  logic        prev_valid;

  logic tohost_hit;
  logic repeat_pc;
  logic hang_hit;
  logic nxt_terminal;

  assign tohost_hit   = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign repeat_pc    = prev_valid && (pc == prev_pc);
  assign hang_hit     = HANG_EN && repeat_pc && (hang_cnt == HANG_LAST);
  assign nxt_terminal = (state_nxt == S_PASS) || (state_nxt == S_FAIL) ||
                        (state_nxt == S_TIMEOUT) || (state_nxt == S_HANG);

  // Next-state selection; in RUN the checks are prioritised pass, fail,
  // timeout, hang.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (tohost_hit)                 state_nxt = (dmem_wdata == 32'd1) ? S_PASS : S_FAIL;
        else if (cycle_count == CNT_LAST) state_nxt = S_TIMEOUT;
        else if (hang_hit)              state_nxt = S_HANG;
      end
      default: state_nxt = state;
    endcase
    if (reset) state_nxt = S_HOLD;
  end

  // State, counters and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_HOLD;
      hold_cnt    <= 8'd0;
      hang_cnt    <= 32'd0;
      prev_pc     <= 32'd0;
      prev_valid  <= 1'b0;
      cycle_count <= '0;
      fail_code   <= 31'd0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      status      <= 3'd0;
    end else begin
      state   <= state_nxt;
      prev_pc <= pc;

      if (state == S_HOLD && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 8'd1;

      if (state == S_RUN) begin
        prev_valid <= 1'b1;
        if (!(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
        if (repeat_pc) begin
          if (!(&hang_cnt)) hang_cnt <= hang_cnt + 32'd1;
        end else begin
          hang_cnt <= 32'd0;
        end
        if (tohost_hit && dmem_wdata != 32'd1) fail_code <= dmem_wdata[31:1];
      end else if (state == S_HOLD) begin
        // The first RUN cycle has no valid predecessor pc to compare with.
        prev_valid <= 1'b0;
        hang_cnt   <= 32'd0;
      end

      cpu_reset <= (state_nxt == S_HOLD) || (nxt_terminal && HOLD_ON_DONE);
      running   <= (state_nxt == S_RUN);
      done      <= nxt_terminal;
      pass      <= (state_nxt == S_PASS);
      status    <= state_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: two controller configurations driven by shared stimulus,
// checked every cycle against a behavioural model plus literal pins.
module tb_cpu_run_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h100;
  logic        dmem_we = 1'b0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;

  always #5 clk = ~clk;

  logic        u0_cr, u0_run, u0_done, u0_pass;
  logic [2:0]  u0_st;
  logic [30:0] u0_fc;
  logic [31:0] u0_cc;
  logic        u1_cr, u1_run, u1_done, u1_pass;
  logic [2:0]  u1_st;
  logic [30:0] u1_fc;
  logic [31:0] u1_cc;

  cpu_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(20), .CNT_W(32), .HANG_CYCLES(8),
                 .TOHOST_ADDR(TOHOST), .HOLD_ON_DONE(1'b1)) u0 (
    .clk(clk), .reset(reset), .pc(pc), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .cpu_reset(u0_cr), .running(u0_run), .done(u0_done),
    .pass(u0_pass), .status(u0_st), .fail_code(u0_fc), .cycle_count(u0_cc));

  cpu_run_ctrl #(.RESET_CYCLES(1), .MAX_CYCLES(20), .CNT_W(32), .HANG_CYCLES(0),
                 .TOHOST_ADDR(TOHOST), .HOLD_ON_DONE(1'b0)) u1 (
    .clk(clk), .reset(reset), .pc(pc), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .cpu_reset(u1_cr), .running(u1_run), .done(u1_done),
    .pass(u1_pass), .status(u1_st), .fail_code(u1_fc), .cycle_count(u1_cc));

  // ---------------- behavioural model ----------------
  // st: 0 hold, 1 run, 2 pass, 3 fail, 4 timeout, 5 hang
  typedef struct {
    int          st;
    int          edges;
    longint      cnt;
    int          rep;
    logic [31:0] ppc;
    bit          pv;
    logic [30:0] fc;
  } mdl_t;

  mdl_t m0, m1;
  bit   mvalid = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  function automatic mdl_t step_model(mdl_t s, int rc, int mc, int hc);
    mdl_t n;
    bit   same;
    n = s;
    if (reset) begin
      n.st = 0; n.edges = 0; n.cnt = 0; n.rep = 0; n.pv = 0; n.fc = '0; n.ppc = pc;
      return n;
    end
    n.ppc = pc;
    if (s.st == 0) begin
      n.edges = s.edges + 1;
      n.pv = 0;
      n.rep = 0;
      if (n.edges >= rc) n.st = 1;
    end else if (s.st == 1) begin
      same  = s.pv && (pc == s.ppc);
      n.cnt = s.cnt + 1;
      n.rep = same ? s.rep + 1 : 0;
      n.pv  = 1;
      if (dmem_we && dmem_addr == TOHOST) begin
        if (dmem_wdata == 32'd1) n.st = 2;
        else begin n.st = 3; n.fc = dmem_wdata[31:1]; end
      end else if (s.cnt == longint'(mc - 1)) n.st = 4;
      else if (hc != 0 && n.rep == hc) n.st = 5;
    end
    return n;
  endfunction

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    m0 = step_model(m0, 4, 20, 8);
    m1 = step_model(m1, 1, 20, 0);
    if (reset) mvalid = 1'b1;
  end

  // ---------------- scoreboard ----------------
  logic [69:0] exp_q[$];

  task automatic cmp(input string nm, input mdl_t m, input bit hod,
                     input logic cr, input logic rn, input logic dn, input logic ps,
                     input logic [2:0] st, input logic [30:0] fc, input logic [31:0] cc);
    logic [69:0] act;
    logic [69:0] exp;
    bit term;
    term = (m.st >= 2);
    exp = {(m.st == 0) || (term && hod), m.st == 1, term, m.st == 2,
           3'(m.st), m.fc, m.cnt[31:0]};
    exp_q.push_back(exp);
    act = {cr, rn, dn, ps, st, fc, cc};
    vecs++;
    if (act !== exp_q.pop_front()) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cr,run,done,pass,status,fail_code,cycles)",
               nm, act, exp);
    end
  endtask

  // Every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      cmp("u0_model", m0, 1'b1, u0_cr, u0_run, u0_done, u0_pass, u0_st, u0_fc, u0_cc);
      cmp("u1_model", m1, 1'b0, u1_cr, u1_run, u1_done, u1_pass, u1_st, u1_fc, u1_cc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic step();
    pc = pc + 32'd4;
    dmem_we = 1'b0;
    tick();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [31:0] wd);
    pc = pc + 32'd4;
    dmem_we = 1'b1;
    dmem_addr = TOHOST;
    dmem_wdata = wd;
    tick();
    dmem_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dmem_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic release_to_run();
    reset = 1'b0;
    steps(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Power-on reset and reset-sequence timing.
    do_reset();
    chk("reset_cpu_reset", 32'(u0_cr), 32'd1);
    chk("reset_status", 32'(u0_st), 32'd0);
    chk("reset_cycles", u0_cc, 32'd0);
    reset = 1'b0;
    steps(3);
    chk("hold_edge3_cpu_reset", 32'(u0_cr), 32'd1);
    chk("hold_edge3_running", 32'(u0_run), 32'd0);
    step();
    chk("run_first_running", 32'(u0_run), 32'd1);
    chk("run_first_cpu_reset", 32'(u0_cr), 32'd0);
    chk("run_first_cycles", u0_cc, 32'd0);
    chk("u1_short_hold_cycles", u1_cc, 32'd3);

    // Pass write in RUN cycle 10.
    steps(10);
    wr(32'd1);
    chk("pass_status", 32'(u0_st), 32'd2);
    chk("pass_flag", 32'(u0_pass), 32'd1);
    chk("pass_done", 32'(u0_done), 32'd1);
    chk("pass_cycles", u0_cc, 32'd11);
    chk("pass_cpu_reset_hold", 32'(u0_cr), 32'd1);
    chk("u1_pass_cpu_reset_free", 32'(u1_cr), 32'd0);
    steps(3);
    chk("pass_cycles_frozen", u0_cc, 32'd11);

    // Reset from PASS, then a fail write, then a late pass write.
    do_reset();
    chk("rst_pass_status", 32'(u0_st), 32'd0);
    chk("rst_pass_cycles", u0_cc, 32'd0);
    release_to_run();
    wr(32'h0000_0007);
    chk("fail_status", 32'(u0_st), 32'd3);
    chk("fail_code", 32'(u0_fc), 32'd3);
    chk("fail_pass_flag", 32'(u0_pass), 32'd0);
    wr(32'd1);
    chk("fail_sticky", 32'(u0_st), 32'd3);

    // Timeout with an advancing pc.
    do_reset();
    chk("rst_fail_code", 32'(u0_fc), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 60 && !u0_done; i++) step();
    chk("timeout_status", 32'(u0_st), 32'd4);
    chk("timeout_cycles", u0_cc, 32'd20);

    // Pass wins over timeout on the last budget cycle.
    do_reset();
    release_to_run();
    steps(19);
    chk("prio_cycles_at_19", u0_cc, 32'd19);
    wr(32'd1);
    chk("prio_pass_status", 32'(u0_st), 32'd2);

    // Hang: pc held at 0x40 from RUN cycle 3.
    do_reset();
    release_to_run();
    steps(3);
    pc = 32'h40;
    for (int i = 0; i < 8; i++) tick();
    chk("hang_not_yet", 32'(u0_st), 32'd1);
    tick();
    chk("hang_status", 32'(u0_st), 32'd5);
    chk("hang_cycles", u0_cc, 32'd12);
    for (int i = 0; i < 30 && !u1_done; i++) tick();
    chk("u1_no_hang_timeout", 32'(u1_st), 32'd4);

    // Hang run broken on the 7th equal cycle.
    do_reset();
    pc = 32'h200;
    release_to_run();
    steps(3);
    pc = 32'h40;
    for (int i = 0; i < 7; i++) tick();
    pc = 32'h44;
    tick();
    for (int i = 0; i < 40 && !u0_done; i++) step();
    chk("hang_broken_timeout", 32'(u0_st), 32'd4);

    // Reset asserted mid-RUN.
    do_reset();
    release_to_run();
    steps(5);
    reset = 1'b1;
    tick();
    chk("rst_run_status", 32'(u0_st), 32'd0);
    chk("rst_run_cpu_reset", 32'(u0_cr), 32'd1);
    chk("rst_run_cycles", u0_cc, 32'd0);
    reset = 1'b0;
    steps(3);
    chk("rerun_hold", 32'(u0_cr), 32'd1);
    step();
    chk("rerun_running", 32'(u0_run), 32'd1);

    // Randomised episodes, model-checked every cycle.
    for (int ep = 0; ep < 30; ep++) begin
      reset = 1'b1;
      dmem_we = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      reset = 1'b0;
      for (int c = 0; c < int'($urandom_range(5, 45)); c++) begin
        case ($urandom_range(0, 3))
          0, 1:    pc = pc;
          2:       pc = pc + 32'd4;
          default: pc = 32'h40 + 32'($urandom_range(0, 1)) * 32'd4;
        endcase
        dmem_we    = ($urandom_range(0, 11) == 0);
        dmem_addr  = ($urandom_range(0, 3) == 0) ? 32'h0000_1004 : TOHOST;
        dmem_wdata = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
        reset      = ($urandom_range(0, 59) == 0);
        tick();
      end
      dmem_we = 1'b0;
      reset = 1'b0;
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
